// File: rtl/mef_gen_pkg.sv
// Shared types for the A/B stimulus generator: state encoding and repeat-count width.
package mef_gen_pkg;

    typedef enum logic [1:0] {
        REPOSO = 2'b00,
        EMITE  = 2'b01,
        PAUSA  = 2'b10,
        FIN    = 2'b11
    } estado_gen_t;

    localparam int ANCHO_REP = 4;

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module contador_sat #(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             limpiar,
    input  logic             habilitar,
    output logic [ANCHO-1:0] cuenta
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta <= '0;
        end else if (limpiar) begin
            cuenta <= '0;
        end else if (habilitar && (cuenta != '1)) begin
            cuenta <= cuenta + 1'b1;
        end
    end

endmodule

// File: rtl/mef_gen.sv
// Serial A/B pattern generator feeding the sequence detector; repeats a latched frame
// n_rep+1 times, then pulses fin. Counts EMITE cycles in which the detector's Z is high.
//
// state  | meaning
// REPOSO | idle, listo=1, waiting for inicio
// EMITE  | driving reg_a/reg_b[indice] on A/B
// PAUSA  | one blank cycle between frames
// FIN    | one-cycle completion pulse
module mef_gen
    import mef_gen_pkg::*;
#(
    parameter int LONGITUD     = 8,
    parameter int ANCHO_CUENTA = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inicio,
    output logic                    listo,
    input  logic [LONGITUD-1:0]     patron_a,
    input  logic [LONGITUD-1:0]     patron_b,
    input  logic [ANCHO_REP-1:0]    n_rep,
    input  logic                    parar,
    input  logic                    Z,
    output logic                    A,
    output logic                    B,
    output logic                    activo,
    output logic                    fin,
    output logic [ANCHO_CUENTA-1:0] cuenta_z,
    output logic [1:0]              estado_depurado
);

    localparam int ANCHO_IDX = (LONGITUD > 1) ? $clog2(LONGITUD) : 1;
    localparam logic [ANCHO_IDX-1:0] IDX_ULTIMO = ANCHO_IDX'(LONGITUD - 1);

    estado_gen_t          estado, estado_sig;
    logic [LONGITUD-1:0]  reg_a, reg_b;
    logic [ANCHO_IDX-1:0] indice;
    logic [ANCHO_REP-1:0] rep;
    logic                 ultimo;
    logic                 acepta;

    assign ultimo = (indice == IDX_ULTIMO);
    assign acepta = (estado == REPOSO) && inicio;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    // parar outranks every other exit from EMITE/PAUSA, including the last symbol.
    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO: if (inicio) estado_sig = EMITE;
            EMITE: begin
                if (parar) begin
                    estado_sig = FIN;
                end else if (ultimo) begin
                    estado_sig = (rep == '0) ? FIN : PAUSA;
                end
            end
            PAUSA:   estado_sig = parar ? FIN : EMITE;
            FIN:     estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a  <= '0;
            reg_b  <= '0;
            indice <= '0;
            rep    <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        reg_a  <= patron_a;
                        reg_b  <= patron_b;
                        rep    <= n_rep;
                        indice <= '0;
                    end
                end
                EMITE: begin
                    if (ultimo) begin
                        indice <= '0;
                        if (!parar && (rep != '0)) begin
                            rep <= rep - 1'b1;
                        end
                    end else begin
                        indice <= indice + 1'b1;
                    end
                end
                default: indice <= '0;
            endcase
        end
    end

    contador_sat #(
        .ANCHO (ANCHO_CUENTA)
    ) u_cuenta_z (
        .clk       (clk),
        .rst       (rst),
        .limpiar   (acepta),
        .habilitar ((estado == EMITE) && Z),
        .cuenta    (cuenta_z)
    );

    // Moore decode straight from the state register so reset clears A/B without an edge.
    assign A               = (estado == EMITE) ? reg_a[indice] : 1'b0;
    assign B               = (estado == EMITE) ? reg_b[indice] : 1'b0;
    assign listo           = (estado == REPOSO);
    assign activo          = (estado == EMITE) || (estado == PAUSA);
    assign fin             = (estado == FIN);
    assign estado_depurado = estado;

endmodule

// File: tb/tb_mef_gen.sv
// Self-checking bench for mef_gen: per-cycle frame/pause/fin schedule computed arithmetically.
module tb_mef_gen;

    localparam int L = 8;
    localparam int W = 4;
    localparam int CMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         inicio;
    logic         listo;
    logic [L-1:0] patron_a, patron_b;
    logic [3:0]   n_rep;
    logic         parar;
    logic         Z;
    logic         A, B, activo, fin;
    logic [W-1:0] cuenta_z;
    logic [1:0]   estado_depurado;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mef_gen #(.LONGITUD(L), .ANCHO_CUENTA(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .inicio          (inicio),
        .listo           (listo),
        .patron_a        (patron_a),
        .patron_b        (patron_b),
        .n_rep           (n_rep),
        .parar           (parar),
        .Z               (Z),
        .A               (A),
        .B               (B),
        .activo          (activo),
        .fin             (fin),
        .cuenta_z        (cuenta_z),
        .estado_depurado (estado_depurado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected cycle k after acceptance: position p=k-1 walks frames of L symbols each
    // followed by one pause; after (n+1)*L+n cycles (or right after parar) comes FIN.
    // z_mode: 0 random, 1 always high, 2 high only on cycles 2,4,6.
    task automatic run(input logic [L-1:0] pa, input logic [L-1:0] pb, input logic [3:0] n,
                       input int stop_at, input int rst_at, input int z_mode, input bit junk);
        int total, p, off, cnt;
        int est;
        bit done;
        logic ea, eb;
        chk("listo_before_start", listo, 1);
        patron_a = pa; patron_b = pb; n_rep = n;
        inicio = 1'b1; parar = 1'b0; Z = 1'b0;
        tick();
        inicio = 1'b0;
        patron_a = L'($urandom); patron_b = L'($urandom); n_rep = 4'($urandom);
        total = (int'(n) + 1) * L + int'(n);
        cnt = 0;
        done = 0;
        for (int k = 1; !done && k <= 400; k++) begin
            p = k - 1;
            off = p % (L + 1);
            if ((stop_at != 0 && k > stop_at) || p >= total) est = 3;
            else if (off == L) est = 2;
            else est = 1;
            ea = (est == 1) ? pa[off] : 1'b0;
            eb = (est == 1) ? pb[off] : 1'b0;
            chk("A", A, ea);
            chk("B", B, eb);
            chk("activo", activo, (est == 1 || est == 2));
            chk("fin", fin, (est == 3));
            chk("listo", listo, 0);
            chk("estado", estado_depurado, est);
            chk("cuenta_z", cuenta_z, cnt);
            if (k == rst_at) begin
                #3 rst = 1'b1;
                #1;
                chk("rst_A", A, 0);
                chk("rst_B", B, 0);
                chk("rst_activo", activo, 0);
                chk("rst_cuenta", cuenta_z, 0);
                chk("rst_listo", listo, 1);
                chk("rst_estado", estado_depurado, 0);
                tick();
                chk("rst_no_fin", fin, 0);
                chk("rst_listo_held", listo, 1);
                rst = 1'b0;
                return;
            end
            if (est == 3) done = 1;
            case (z_mode)
                1:       Z = 1'b1;
                2:       Z = (k == 2 || k == 4 || k == 6);
                default: Z = 1'($urandom);
            endcase
            if (est == 1 && Z && cnt < CMAX) cnt++;
            parar  = (k == stop_at);
            inicio = (junk && !done) ? 1'($urandom) : 1'b0;
            tick();
        end
        chk("fin_reached", done, 1);
        parar = 1'b0; inicio = 1'b0; Z = 1'b1;
        chk("listo_after_fin", listo, 1);
        chk("fin_single", fin, 0);
        chk("cuenta_after_fin", cuenta_z, cnt);
        tick();
        chk("cuenta_held_idle", cuenta_z, cnt);
        chk("estado_idle", estado_depurado, 0);
        Z = 1'b0;
    endtask

    initial begin
        int n, tot;
        rst = 1'b1; inicio = 1'b0; parar = 1'b0; Z = 1'b0;
        patron_a = '0; patron_b = '0; n_rep = '0;
        #2;
        chk("reset_listo", listo, 1);
        chk("reset_A", A, 0);
        chk("reset_B", B, 0);
        chk("reset_activo", activo, 0);
        chk("reset_fin", fin, 0);
        chk("reset_cuenta", cuenta_z, 0);
        chk("reset_estado", estado_depurado, 0);
        tick();
        rst = 1'b0;
        tick();

        // single frame, first symbol one cycle after acceptance
        run(8'b0000_0011, 8'h00, 4'd0, 0, 0, 0, 0);
        // Z high on exactly three EMITE cycles
        run(8'h3C, 8'hC3, 4'd0, 0, 0, 2, 0);
        chk("three_hits", cuenta_z, 3);
        // three frames with pauses between them
        run(8'hA5, 8'h5A, 4'd2, 0, 0, 0, 0);
        // abort during the 4th EMITE cycle
        run(8'h96, 8'h69, 4'd3, 4, 0, 0, 0);
        // abort exactly on a last symbol, which parar must outrank
        run(8'hF0, 8'h0F, 4'd1, 8, 0, 0, 0);
        // asynchronous reset mid-EMITE, then a normal run
        run(8'hFF, 8'hFF, 4'd1, 0, 5, 1, 0);
        run(8'h81, 8'h7E, 4'd0, 0, 0, 0, 0);
        // saturation over 128 EMITE cycles with spurious inicio pulses
        run(8'hC9, 8'h36, 4'd15, 0, 0, 1, 1);
        chk("saturated", cuenta_z, CMAX);

        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(3, 0);
            tot = (n + 1) * L + n;
            run(L'($urandom), L'($urandom), 4'(n),
                ($urandom_range(1, 0) == 1) ? $urandom_range(tot, 1) : 0, 0, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mef_gen.md
Name: mef_gen

Overview:
Stimulus generator for the A/B sequence-detector FSM. It is the transmitting end of the A/B symbol stream that the detector consumes.
- Accepts a parallel pattern pair through a start handshake, then emits it serially on A/B, one symbol per clock, LSB first.
- Repeats the frame a programmable number of times, then pulses a completion flag.
- Counts the cycles in which the detector's Z returns high during emission, closing the loop for on-chip self-test.

Parameters:
LONGITUD, 8, symbols per frame (width of patron_a/patron_b); must be ≥2
ANCHO_CUENTA, 8, width of the saturating Z-hit counter cuenta_z

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
inicio  input  1  start request; accepted when inicio && listo at a rising edge
listo  output  1  generator idle and ready to accept a new pattern
patron_a  input  LONGITUD  A symbols, bit 0 emitted first
patron_b  input  LONGITUD  B symbols, bit 0 emitted first
n_rep  input  4  extra repetitions; total frames = n_rep+1
parar  input  1  synchronous abort request
Z  input  1  detector output fed back for hit counting
A  output  1  serial A symbol
B  output  1  serial B symbol
activo  output  1  high while in EMITE or PAUSA
fin  output  1  one-cycle completion pulse
cuenta_z  output  ANCHO_CUENTA  number of EMITE cycles with Z=1, saturating
estado_depurado  output  2  current state encoding, for debug

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high.
- Reset values: state REPOSO; listo=1; A=B=0; activo=0; fin=0; cuenta_z=0; estado_depurado=2'b00; index and repeat registers 0. These take effect immediately, without waiting for a clock edge.
- States, encoded in the package: REPOSO=00, EMITE=01, PAUSA=10, FIN=11.
- Outputs are Moore, decoded from the registered state:
  - A = reg_a[indice] and B = reg_b[indice] only in EMITE; otherwise A=B=0.
  - listo = (REPOSO); activo = (EMITE|PAUSA); fin = (FIN).
- REPOSO:
  - At an edge where inicio=1: latch reg_a=patron_a, reg_b=patron_b, rep=n_rep; set indice=0; clear cuenta_z; go to EMITE.
  - The first symbol is visible in the cycle immediately after the accepting edge (latency 1).
  - parar is ignored in REPOSO.
- EMITE:
  - Each edge increments indice.
  - At indice==LONGITUD-1: if rep==0, go to FIN; otherwise decrement rep, set indice=0, and go to PAUSA.
- PAUSA: exactly one cycle with A=B=0, then return to EMITE at indice=0.
- FIN: exactly one cycle, then REPOSO.
- Total busy time = (n_rep+1)*LONGITUD EMITE cycles + n_rep PAUSA cycles + 1 FIN cycle.
- parar=1 in EMITE or PAUSA: go to FIN at the next edge. This takes priority over all other transitions, including the last-symbol transition. cuenta_z keeps its value.
- inicio while not in REPOSO is ignored. Changes to patron_a, patron_b or n_rep after acceptance have no effect.
- cuenta_z:
  - Increments at each edge where state==EMITE and Z==1.
  - Saturates at 2^ANCHO_CUENTA-1 (no wrap).
  - Holds its value after FIN until the next acceptance.
- Unused/illegal encoding: the next state is REPOSO.
- Reset asserted mid-frame: abort immediately; A/B drop to 0 asynchronously; no fin pulse is generated.

Decomposition:
- Package mef_gen_pkg:
  - typedef estado_gen_t with the four state encodings
  - localparam for the n_rep width (4)
- Sub-module contador_sat: parameterized width, with
  - async active-high rst
  - synchronous clear and enable inputs
  - saturation at all-ones
  Used for cuenta_z.
- The FSM, shift/index logic and output decode stay in mef_gen.

Test Plan:
1. patron_a=8'b0000_0011, patron_b=8'h00, n_rep=0, inicio pulse -> A=1,1,0,0,0,0,0,0 on cycles 1-8 after accept, B=0 throughout; fin=1 on cycle 9; listo=1 on cycle 10.
2. Bench Z model high for exactly 3 EMITE cycles of a single frame -> cuenta_z=3 after fin, held through REPOSO.
3. n_rep=2, patron_a=8'hA5 -> three identical 8-symbol frames separated by single A=B=0 PAUSA cycles; fin on cycle 27 after accept; activo high for cycles 1-26.
4. parar asserted during the 4th EMITE cycle (n_rep=3) -> state FIN at the next edge, fin pulses once, A=B=0, listo returns the cycle after.
5. rst asserted between clock edges mid-EMITE -> A, B, activo, cuenta_z go to 0 and listo goes to 1 without a clock edge; no fin pulse; a new inicio after reset release works normally.
6. ANCHO_CUENTA=4, n_rep=15, Z tied to 1 -> cuenta_z saturates at 15 (no wrap to 0) across the 128 EMITE cycles; inicio pulses during emission are ignored.
